// File: rtl/softmax_pkg_16.sv
// -----------------------------------------------------------------------------
// softmax_pkg_16
// Shared constants and types for the 16-bit softmax pipeline.
//   SM_DATA_SIZE       : element / ln word width
//   SM_NUMBER_OF_DATA  : elements per frame (2..255)
//   SM_LN_SHIFT        : right shift aligning ln fixed point to element format
//   sched_state_t      : second-subtraction scheduler FSM encoding
// -----------------------------------------------------------------------------
package softmax_pkg_16;

    localparam int SM_DATA_SIZE      = 16;
    localparam int SM_NUMBER_OF_DATA = 10;
    localparam int SM_LN_SHIFT       = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LN = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_DONE    = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sub_2_sched_16_if.sv
// -----------------------------------------------------------------------------
// sub_2_sched_16_if
// Bundles the element input, ln input and subtractor issue port of the
// second-subtraction scheduler.
//   slave  : scheduler side (ds_*, ln_*, sub_ready_i in; rest out)
//   master : environment side (mirror image)
// -----------------------------------------------------------------------------
interface sub_2_sched_16_if #(
    parameter int DATA_SIZE = softmax_pkg_16::SM_DATA_SIZE
);
    logic [DATA_SIZE-1:0] ds_data_i;
    logic                 ds_valid_i;
    logic                 ds_ready_o;
    logic [DATA_SIZE-1:0] ln_data_i;
    logic                 ln_valid_i;
    logic [DATA_SIZE-1:0] sub_a_o;
    logic [DATA_SIZE-1:0] sub_b_o;
    logic [7:0]           sub_idx_o;
    logic                 sub_valid_o;
    logic                 sub_ready_i;
    logic                 frame_done_o;
    logic                 busy_o;
    logic                 err_ln_o;

    modport slave (
        input  ds_data_i, ds_valid_i, ln_data_i, ln_valid_i, sub_ready_i,
        output ds_ready_o, sub_a_o, sub_b_o, sub_idx_o, sub_valid_o,
               frame_done_o, busy_o, err_ln_o
    );

    modport master (
        output ds_data_i, ds_valid_i, ln_data_i, ln_valid_i, sub_ready_i,
        input  ds_ready_o, sub_a_o, sub_b_o, sub_idx_o, sub_valid_o,
               frame_done_o, busy_o, err_ln_o
    );
endinterface

// File: rtl/sub_2_bank_16.sv
// -----------------------------------------------------------------------------
// sub_2_bank_16
// Ping-pong frame storage. Elements fill bank[wr_bank] in order; the bank is
// marked full on its last element and writing moves to the other bank.
//   clk, rst      : clock, async active-high reset (flags/pointers only)
//   i_wr_data     : element to store
//   i_wr_valid    : element strobe (dropped while o_wr_ready is low)
//   o_wr_ready    : current write bank is not full
//   i_clr_full    : release bank i_rd_bank after it has been issued
//   i_rd_bank     : bank selected for reading
//   i_rd_idx      : element index for the combinational read port
//   o_rd_data     : bank[i_rd_bank][i_rd_idx]
//   o_full        : per-bank full flags
// -----------------------------------------------------------------------------
module sub_2_bank_16 #(
    parameter int DATA_SIZE      = softmax_pkg_16::SM_DATA_SIZE,
    parameter int NUMBER_OF_DATA = softmax_pkg_16::SM_NUMBER_OF_DATA,
    parameter int IDX_W          = $clog2(NUMBER_OF_DATA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic                 i_clr_full,
    input  logic                 i_rd_bank,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [DATA_SIZE-1:0] o_rd_data,
    output logic [1:0]           o_full
);

    logic [DATA_SIZE-1:0] r_mem [2][NUMBER_OF_DATA];
    logic [1:0]           r_full;
    logic                 r_wr_bank;
    logic [7:0]           r_wr_cnt;
    logic                 w_wr_fire;
    logic                 w_wr_last;

    assign o_wr_ready = ~r_full[r_wr_bank];
    assign w_wr_fire  = i_wr_valid & o_wr_ready;
    assign w_wr_last  = (r_wr_cnt == 8'(NUMBER_OF_DATA - 1));

    // Storage is deliberately not reset; full flags gate every read.
    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_mem[r_wr_bank][r_wr_cnt[IDX_W-1:0]] <= i_wr_data;
    end

    // Set and clear never hit the same bank: the read side only releases a
    // bank it has finished issuing, which the write side cannot be filling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= 8'd0;
        end else begin
            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_cnt          <= 8'd0;
                    r_wr_bank         <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 8'd1;
                end
            end
            if (i_clr_full)
                r_full[i_rd_bank] <= 1'b0;
        end
    end

    assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];
    assign o_full    = r_full;

endmodule

// File: rtl/sub_2_sched_16.sv
// -----------------------------------------------------------------------------
// sub_2_sched_16
// Issues (element, aligned ln) pairs of the oldest full frame to the x - ln
// subtractor, one per accepted handshake, while the next frame loads into the
// other bank.
//   clock_i, reset_i : clock, async active-high reset
//   bus_if (slave)   : ds_* element input, ln_* input, sub_* issue port,
//                      frame_done_o / busy_o / err_ln_o status
//
// state   | meaning
// IDLE    | waiting for the read bank to fill
// WAIT_LN | frame stored, waiting for its ln(sum)
// ISSUE   | presenting operand pairs to the subtractor
// DONE    | frame issued; pulse frame_done, release bank, swap read bank
// -----------------------------------------------------------------------------
module sub_2_sched_16
    import softmax_pkg_16::*;
#(
    parameter int DATA_SIZE      = SM_DATA_SIZE,
    parameter int NUMBER_OF_DATA = SM_NUMBER_OF_DATA,
    parameter int LN_SHIFT       = SM_LN_SHIFT
) (
    input  logic             clock_i,
    input  logic             reset_i,
    sub_2_sched_16_if.slave  bus_if
);

    localparam int         IDX_W    = $clog2(NUMBER_OF_DATA);
    localparam logic [7:0] LAST_IDX = 8'(NUMBER_OF_DATA - 1);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic                 r_rd_bank;
    logic                 r_err;
    logic [DATA_SIZE-1:0] r_sub_a;
    logic [DATA_SIZE-1:0] r_sub_b;
    logic [7:0]           r_sub_idx;
    logic                 r_sub_valid;
    logic [DATA_SIZE-1:0] w_sub_a_nxt;
    logic [DATA_SIZE-1:0] w_sub_b_nxt;
    logic [7:0]           w_sub_idx_nxt;
    logic                 w_sub_valid_nxt;
    logic                 w_hs;
    logic                 w_is_last;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [DATA_SIZE-1:0] w_rd_data;
    logic [1:0]           w_full;
    logic                 w_wr_ready;

    sub_2_bank_16 #(
        .DATA_SIZE      (DATA_SIZE),
        .NUMBER_OF_DATA (NUMBER_OF_DATA),
        .IDX_W          (IDX_W)
    ) u_bank (
        .clk        (clock_i),
        .rst        (reset_i),
        .i_wr_data  (bus_if.ds_data_i),
        .i_wr_valid (bus_if.ds_valid_i),
        .o_wr_ready (w_wr_ready),
        .i_clr_full (r_state == ST_DONE),
        .i_rd_bank  (r_rd_bank),
        .i_rd_idx   (w_rd_idx),
        .o_rd_data  (w_rd_data),
        .o_full     (w_full)
    );

    assign w_hs      = r_sub_valid & bus_if.sub_ready_i;
    assign w_is_last = (r_sub_idx == LAST_IDX);

    // Read port looks one element ahead while issuing so the next operand is
    // ready at the handshake; index 0 otherwise (first load from WAIT_LN).
    assign w_rd_idx = (r_state == ST_ISSUE && !w_is_last)
                      ? r_sub_idx[IDX_W-1:0] + IDX_W'(1) : '0;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_full[r_rd_bank])   w_state_nxt = ST_WAIT_LN;
            ST_WAIT_LN: if (bus_if.ln_valid_i)   w_state_nxt = ST_ISSUE;
            ST_ISSUE:   if (w_hs && w_is_last)   w_state_nxt = ST_DONE;
            ST_DONE:                             w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sub_a_nxt     = r_sub_a;
        w_sub_b_nxt     = r_sub_b;
        w_sub_idx_nxt   = r_sub_idx;
        w_sub_valid_nxt = r_sub_valid;
        if (r_state == ST_WAIT_LN && bus_if.ln_valid_i) begin
            w_sub_a_nxt     = w_rd_data;
            w_sub_b_nxt     = bus_if.ln_data_i >> LN_SHIFT;
            w_sub_idx_nxt   = 8'd0;
            w_sub_valid_nxt = 1'b1;
        end else if (r_state == ST_ISSUE && w_hs) begin
            if (w_is_last) begin
                w_sub_valid_nxt = 1'b0;
            end else begin
                w_sub_a_nxt   = w_rd_data;
                w_sub_idx_nxt = r_sub_idx + 8'd1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_sub_a     <= '0;
            r_sub_b     <= '0;
            r_sub_idx   <= 8'd0;
            r_sub_valid <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_sub_a     <= w_sub_a_nxt;
            r_sub_b     <= w_sub_b_nxt;
            r_sub_idx   <= w_sub_idx_nxt;
            r_sub_valid <= w_sub_valid_nxt;
            if (r_state == ST_DONE)
                r_rd_bank <= ~r_rd_bank;
            if (bus_if.ln_valid_i && r_state != ST_WAIT_LN)
                r_err <= 1'b1;
        end
    end

    assign bus_if.ds_ready_o   = w_wr_ready;
    assign bus_if.sub_a_o      = r_sub_a;
    assign bus_if.sub_b_o      = r_sub_b;
    assign bus_if.sub_idx_o    = r_sub_idx;
    assign bus_if.sub_valid_o  = r_sub_valid;
    assign bus_if.frame_done_o = (r_state == ST_DONE);
    assign bus_if.busy_o       = (r_state != ST_IDLE) | (|w_full);
    assign bus_if.err_ln_o     = r_err;

endmodule

// File: tb/tb_sub_2_sched_16.sv
// -----------------------------------------------------------------------------
// tb_sub_2_sched_16
// Directed bench for the second-subtraction scheduler. Inputs change and
// outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sub_2_sched_16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc;

    sub_2_sched_16_if bus ();

    sub_2_sched_16 dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus_if  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input logic [15:0] base);
        for (int i = 0; i < 10; i++) begin
            bus.ds_valid_i = 1'b1;
            bus.ds_data_i  = base + 16'(i);
            tick();
        end
        bus.ds_valid_i = 1'b0;
    endtask

    task automatic ln_pulse(input logic [15:0] v);
        bus.ln_valid_i = 1'b1;
        bus.ln_data_i  = v;
        tick();
        bus.ln_valid_i = 1'b0;
    endtask

    // Accepts stop_k transfers; every cycle inside the frame must present
    // element base+k at index k, stalled or not.
    task automatic drain(input logic [15:0] base, input logic [15:0] exp_b,
                         input bit toggle, input int stop_k, output int cycles);
        int k;
        int c;
        bit rdy;
        k = 0;
        c = 0;
        while (k < stop_k && c < 200) begin
            rdy = toggle ? (c % 2 == 0) : 1'b1;
            bus.sub_ready_i = rdy;
            check_val($sformatf("valid[%0d]", k), 32'(bus.sub_valid_o), 32'd1);
            check_val($sformatf("a[%0d]", k), 32'(bus.sub_a_o), 32'(base + 16'(k)));
            check_val($sformatf("idx[%0d]", k), 32'(bus.sub_idx_o), 32'(k));
            check_val($sformatf("b[%0d]", k), 32'(bus.sub_b_o), 32'(exp_b));
            if (rdy && bus.sub_valid_o)
                k++;
            tick();
            c++;
        end
        bus.sub_ready_i = 1'b0;
        check_val("xfer_count", 32'(k), 32'(stop_k));
        cycles = c;
    endtask

    task automatic check_done();
        check_val("done_pulse", 32'(bus.frame_done_o), 32'd1);
        check_val("valid_after_last", 32'(bus.sub_valid_o), 32'd0);
        tick();
        check_val("done_low", 32'(bus.frame_done_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(bus.sub_valid_o), 32'd0);
        check_val({tag, "_a"}, 32'(bus.sub_a_o), 32'd0);
        check_val({tag, "_b"}, 32'(bus.sub_b_o), 32'd0);
        check_val({tag, "_idx"}, 32'(bus.sub_idx_o), 32'd0);
        check_val({tag, "_done"}, 32'(bus.frame_done_o), 32'd0);
        check_val({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check_val({tag, "_err"}, 32'(bus.err_ln_o), 32'd0);
        check_val({tag, "_ready"}, 32'(bus.ds_ready_o), 32'd1);
    endtask

    initial begin
        bus.ds_data_i   = '0;
        bus.ds_valid_i  = 1'b0;
        bus.ln_data_i   = '0;
        bus.ln_valid_i  = 1'b0;
        bus.sub_ready_i = 1'b0;

        rst = 1'b1;
        #12;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic frame, subtractor always ready
        write_frame(16'h0100);
        check_val("busy_loaded", 32'(bus.busy_o), 32'd1);
        check_val("no_issue_before_ln", 32'(bus.sub_valid_o), 32'd0);
        tick();
        ln_pulse(16'h0C80);
        check_val("ln_no_err", 32'(bus.err_ln_o), 32'd0);
        drain(16'h0100, 16'h0032, 1'b0, 10, cyc);
        check_val("issue_cycles", 32'(cyc), 32'd10);
        check_done();

        // Ready toggling every cycle; ln MSB set shows zero extension
        write_frame(16'h0200);
        tick();
        ln_pulse(16'hFFFF);
        drain(16'h0200, 16'h03FF, 1'b1, 10, cyc);
        check_done();

        // Two frames back-to-back with no ln: write side blocks
        write_frame(16'h0300);
        write_frame(16'h0400);
        check_val("ready_both_full", 32'(bus.ds_ready_o), 32'd0);
        bus.ds_valid_i = 1'b1;
        bus.ds_data_i  = 16'hDEAD;
        tick();
        bus.ds_valid_i = 1'b0;
        check_val("ready_after_drop", 32'(bus.ds_ready_o), 32'd0);
        check_val("no_issue_wait", 32'(bus.sub_valid_o), 32'd0);
        ln_pulse(16'h1234);
        drain(16'h0300, 16'h0048, 1'b0, 10, cyc);
        check_val("done_a", 32'(bus.frame_done_o), 32'd1);
        check_val("ready_in_done", 32'(bus.ds_ready_o), 32'd0);
        tick();
        check_val("ready_after_done", 32'(bus.ds_ready_o), 32'd1);
        tick();
        // exactly final handshake + 3: an early or late FSM flags err or stalls
        ln_pulse(16'h003F);
        check_val("valid_b_plus3", 32'(bus.sub_valid_o), 32'd1);
        check_val("err_b_plus3", 32'(bus.err_ln_o), 32'd0);
        fork
            write_frame(16'h0600);
            drain(16'h0400, 16'h0000, 1'b0, 10, cyc);
        join
        check_val("done_b", 32'(bus.frame_done_o), 32'd1);
        tick();
        tick();
        ln_pulse(16'h0040);
        check_val("valid_c_plus3", 32'(bus.sub_valid_o), 32'd1);
        drain(16'h0600, 16'h0001, 1'b0, 10, cyc);
        check_done();
        check_val("err_clean", 32'(bus.err_ln_o), 32'd0);

        // Stray ln while idle with empty banks
        ln_pulse(16'h0C80);
        check_val("err_set", 32'(bus.err_ln_o), 32'd1);
        check_val("stray_no_issue", 32'(bus.sub_valid_o), 32'd0);
        tick();
        tick();
        check_val("stray_still_idle", 32'(bus.sub_valid_o), 32'd0);
        check_val("stray_not_busy", 32'(bus.busy_o), 32'd0);
        write_frame(16'h0500);
        tick();
        ln_pulse(16'h0C80);
        drain(16'h0500, 16'h0032, 1'b0, 10, cyc);
        check_done();
        check_val("err_sticky", 32'(bus.err_ln_o), 32'd1);

        // Reset mid-frame at index 5
        write_frame(16'h0700);
        tick();
        ln_pulse(16'h0C80);
        drain(16'h0700, 16'h0032, 1'b0, 5, cyc);
        check_val("mid_idx", 32'(bus.sub_idx_o), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        tick();
        write_frame(16'h0800);
        tick();
        ln_pulse(16'h0C80);
        drain(16'h0800, 16'h0032, 1'b0, 10, cyc);
        check_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_2_sched_16.md
# sub_2_sched_16

Scheduler for the second subtraction stage (x_i − ln Σe) of the 16-bit softmax pipeline. It collects each frame's downscaled elements into one of two ping-pong banks and holds that frame's ln result. Once both are present, it issues one (element, aligned-ln) operand pair per cycle to the subtractor under a valid/ready handshake. Two banks let frame k+1 load while frame k drains.

## Interface
- DATA_SIZE, 16, element/ln word width
- NUMBER_OF_DATA, 10, elements per frame (2..255)
- LN_SHIFT, 6, right-shift aligning ln fixed point to element format
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- ds_data_i  in  DATA_SIZE  downscaled element
- ds_valid_i  in  1  element strobe
- ds_ready_o  out  1  write bank can accept
- ln_data_i  in  DATA_SIZE  ln(sum) for oldest full frame
- ln_valid_i  in  1  ln strobe
- sub_a_o  out  DATA_SIZE  element operand
- sub_b_o  out  DATA_SIZE  {LN_SHIFT'b0, ln[DATA_SIZE-1:LN_SHIFT]}
- sub_idx_o  out  8  element index of current issue
- sub_valid_o  out  1  operands valid
- sub_ready_i  in  1  subtractor accepts
- frame_done_o  out  1  one-cycle pulse, frame fully issued
- busy_o  out  1  state ≠ IDLE or any bank full
- err_ln_o  out  1  sticky: ln_valid_i arrived when not in WAIT_LN

## Operation
- Banks: bank[0..1][0..N-1], full[1:0], wr_bank, wr_cnt (8b), rd_bank.
- ds_ready_o = ~full[wr_bank]. Element written when ds_valid_i && ds_ready_o at bank[wr_bank][wr_cnt]; wr_cnt++. On write with wr_cnt==N-1: full[wr_bank]<=1, wr_cnt<=0, wr_bank toggles. ds_valid_i while ds_ready_o=0 is dropped, no error.
- FSM states IDLE, WAIT_LN, ISSUE, DONE:
- IDLE: full[rd_bank] -> WAIT_LN.
- WAIT_LN: ln_valid_i -> capture ln, load sub_a_o=bank[rd_bank][0], sub_b_o aligned ln, sub_idx_o=0, sub_valid_o<=1 -> ISSUE.
- ISSUE: outputs hold stable while sub_valid_o && ~sub_ready_i. On handshake with idx<N-1: load element idx+1, stay. On handshake with idx==N-1: sub_valid_o<=0 -> DONE.
- DONE: frame_done_o=1, full[rd_bank]<=0, rd_bank toggles -> IDLE.
- ln_valid_i outside WAIT_LN: ignored, err_ln_o<=1 (cleared only by reset).
- Element write to wr_bank and full-clear of rd_bank in same cycle are legal (distinct banks); full-set and full-clear never target the same bank.
- sub_b_o zero-extends; no sign handling, no saturation.

## Timing
- Reset (async assert): sub_valid_o=0, sub_a_o=0, sub_b_o=0, sub_idx_o=0, frame_done_o=0, busy_o=0, err_ln_o=0, ds_ready_o=1 (full=0), wr/rd_bank=0, state IDLE. Bank contents not reset. Reset mid-frame discards both banks and ln.
- Last element write (cycle t): full visible t+1, WAIT_LN at t+2.
- ln_valid_i in WAIT_LN at cycle t -> sub_valid_o=1 at t+1.
- Throughput 1 element/cycle with sub_ready_i held high: frame issue = N cycles, then DONE 1 cycle, IDLE 1 cycle; next frame WAIT_LN at +3 after final handshake.
- frame_done_o high exactly the cycle after final handshake.
- Both banks full: ds_ready_o=0 until DONE of rd_bank; ready returns the cycle after DONE.

## Structure
- Package softmax_pkg_16: DATA_SIZE, NUMBER_OF_DATA, LN_SHIFT defaults, FSM state encoding (2b: IDLE=0, WAIT_LN=1, ISSUE=2, DONE=3).
- Sub-module sub_2_bank_16: dual-bank storage, wr_cnt/wr_bank, full flags, combinational read port (rd_bank, idx). Top holds FSM, ln register, output registers.

## Test plan
- Frame of 10 elements 0x0100..0x0109, then ln=0x0C80, ready=1 -> sub_b_o=0x0032, sub_a_o 0x0100..0x0109 on 10 consecutive cycles, frame_done_o pulse, idx 0..9.
- Ready toggled 1/0 each cycle mid-frame -> outputs held during stall, 10 transfers, no duplicates/skips.
- Load two frames back-to-back without ln -> ds_ready_o=0 after 20 writes; 21st write dropped; after frame 0 DONE, ready=1 next cycle.
- ln_valid_i pulsed in IDLE with empty banks -> err_ln_o=1, no issue; later proper ln still processes the frame.
- Frame 1 loaded while frame 0 issues -> frame 1 WAIT_LN 3 cycles after frame 0 final handshake, data correct.
- reset_i asserted at idx 5 -> all outputs 0 immediately, ds_ready_o=1; fresh frame runs normally.
